// File: rtl/linkinit_state_pkg.sv
// linkinit_state_pkg: sideband message codes and the debug view shared by the
// LINKINIT handler and its TX message holder.
package linkinit_state_pkg;

  // Sideband message codes. SB_NONE is the idle value on the message buses.
  typedef enum logic [7:0] {
    SB_NONE               = 8'h00,
    SB_ACTIVE_REQ         = 8'h01,
    SB_ACTIVE_RESP        = 8'h02,
    SB_LINKINIT_DONE_REQ  = 8'h85,
    SB_LINKINIT_DONE_RESP = 8'h8A
  } SB_msg_t;

  // Width of the retry count as seen on the debug port.
  localparam int DBG_CNT_W = 8;

  // Snapshot of the handler's internal state for checkers.
  typedef struct packed {
    logic [2:0]           state;
    logic                 req_rcvd;
    logic                 resp_rcvd;
    logic                 resp_sent;
    logic [DBG_CNT_W-1:0] retry_cnt;
  } linkinit_dbg_t;

endpackage

// File: rtl/sb_tx_msg_holder.sv
// sb_tx_msg_holder: registers one sideband TX message and its valid, holding
// both until the sideband accepts it (valid & send_next_i) or clear_i aborts.
// Handshake: the message is transferred on a clock edge where valid_o=1 and
// send_next_i=1; valid_o drops on that edge and msg_o returns to SB_NONE.
module sb_tx_msg_holder
  import linkinit_state_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    clear_i,
  input  logic    load_i,
  input  SB_msg_t msg_i,
  input  logic    send_next_i,
  output SB_msg_t msg_o,
  output logic    valid_o,
  output logic    sent_o
);

  SB_msg_t msg_q, msg_d;
  logic    valid_q, valid_d;

  assign sent_o  = valid_q & send_next_i;
  assign msg_o   = msg_q;
  assign valid_o = valid_q;

  // Next message/valid: abort beats a new load, a new load beats completion.
  always_comb begin
    msg_d   = msg_q;
    valid_d = valid_q;
    if (clear_i) begin
      msg_d   = SB_NONE;
      valid_d = 1'b0;
    end else if (load_i) begin
      msg_d   = msg_i;
      valid_d = 1'b1;
    end else if (sent_o) begin
      msg_d   = SB_NONE;
      valid_d = 1'b0;
    end
  end

  // Message holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_q   <= SB_NONE;
      valid_q <= 1'b0;
    end else begin
      msg_q   <= msg_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/linkinit_state.sv
// linkinit_state: LTSM LINKINIT handler. Sends LINKINIT done REQ, answers the
// partner's REQ with RESP, and raises LINKINIT_done_o once our RESP is sent and
// the partner's RESP is received. Mainband is not touched here.
// Optional build macro LINKINIT_RETRY_LIMIT_EN: bounds REQ retries to
// MAX_RETRY and adds the ERROR state (LINKINIT_error_o); otherwise retries are
// unbounded and LINKINIT_error_o is tied 0.
// RX handshake: a message is consumed on any edge where SB_RX_msg_req_o=1 and
// SB_RX_msg_valid_i=1; SB_RX_msg_req_o is high only while waiting for replies.
module linkinit_state
  import linkinit_state_pkg::*;
#(
  parameter int MAX_RETRY   = 4,
  parameter int RETRY_CNT_W = 3
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  input  logic          enable_i,
  output logic          LINKINIT_done_o,
  output logic          LINKINIT_error_o,
  output SB_msg_t       SB_TX_msg_o,
  output logic [63:0]   SB_TX_dataBus_o,
  output logic          SB_TX_msg_valid_o,
  input  logic          SB_TX_msg_sendNextFlag_i,
  input  SB_msg_t       SB_RX_msg_i,
  input  logic [63:0]   SB_RX_dataBus_i,
  output logic          SB_RX_msg_req_o,
  input  logic          SB_RX_msg_valid_i,
  input  logic          SBmessage_retry_timeout_flag,
  output logic          reset_SBmessage_retry_timeout,
  output logic          reset_state_timeout_counter_o,
  output linkinit_dbg_t dbg_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TX_REQ  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_TX_RESP = 3'd3,
`ifdef LINKINIT_RETRY_LIMIT_EN
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
`else
    ST_DONE    = 3'd4
`endif
  } state_t;

  state_t  state_q, state_d;
  logic    req_rcvd_q, req_rcvd_d;
  logic    resp_rcvd_q, resp_rcvd_d;
  logic    resp_sent_q, resp_sent_d;
  logic    pulse_state_q, pulse_state_d;
  logic    pulse_retry_q, pulse_retry_d;
  logic    tx_load, tx_clear, tx_sent, rx_take;
  SB_msg_t tx_load_msg;
`ifdef LINKINIT_RETRY_LIMIT_EN
  logic [RETRY_CNT_W-1:0] retry_cnt_q, retry_cnt_d;
`endif

  // The payload is never used in this exchange, in either direction.
  assign SB_TX_dataBus_o = '0;

  assign SB_RX_msg_req_o = (state_q == ST_WAIT);
  assign rx_take         = SB_RX_msg_req_o & SB_RX_msg_valid_i;
  assign LINKINIT_done_o = (state_q == ST_DONE);
`ifdef LINKINIT_RETRY_LIMIT_EN
  assign LINKINIT_error_o = (state_q == ST_ERROR);
`else
  assign LINKINIT_error_o = 1'b0;
`endif

  assign reset_state_timeout_counter_o = pulse_state_q;
  assign reset_SBmessage_retry_timeout = pulse_retry_q;

  sb_tx_msg_holder u_tx_holder (
    .clk         (clk_100MHz),
    .rst         (reset),
    .clear_i     (tx_clear),
    .load_i      (tx_load),
    .msg_i       (tx_load_msg),
    .send_next_i (SB_TX_msg_sendNextFlag_i),
    .msg_o       (SB_TX_msg_o),
    .valid_o     (SB_TX_msg_valid_o),
    .sent_o      (tx_sent)
  );

  // Next state, flags, timer-restart pulses and TX holder control.
  always_comb begin
    state_d       = state_q;
    req_rcvd_d    = req_rcvd_q;
    resp_rcvd_d   = resp_rcvd_q;
    resp_sent_d   = resp_sent_q;
    pulse_state_d = 1'b0;
    pulse_retry_d = 1'b0;
    tx_load       = 1'b0;
    tx_load_msg   = SB_NONE;
    tx_clear      = 1'b0;
`ifdef LINKINIT_RETRY_LIMIT_EN
    retry_cnt_d   = retry_cnt_q;
`endif
    if (!enable_i) begin
      // Leaving the state: drop everything, including a message in flight.
      state_d     = ST_IDLE;
      req_rcvd_d  = 1'b0;
      resp_rcvd_d = 1'b0;
      resp_sent_d = 1'b0;
      tx_clear    = 1'b1;
`ifdef LINKINIT_RETRY_LIMIT_EN
      retry_cnt_d = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d       = ST_TX_REQ;
          tx_load       = 1'b1;
          tx_load_msg   = SB_LINKINIT_DONE_REQ;
          pulse_state_d = 1'b1;
          pulse_retry_d = 1'b1;
        end
        ST_TX_REQ: begin
          if (tx_sent) begin
            state_d       = ST_WAIT;
            pulse_retry_d = 1'b1;
          end
        end
        ST_WAIT: begin
          // A consumed RX message takes priority over the retry timeout.
          if (rx_take) begin
            if (SB_RX_msg_i == SB_LINKINIT_DONE_REQ) begin
              req_rcvd_d  = 1'b1;
              state_d     = ST_TX_RESP;
              tx_load     = 1'b1;
              tx_load_msg = SB_LINKINIT_DONE_RESP;
            end else if (SB_RX_msg_i == SB_LINKINIT_DONE_RESP) begin
              resp_rcvd_d = 1'b1;
            end
          end else if (resp_rcvd_q && resp_sent_q) begin
            state_d = ST_DONE;
          end else if (SBmessage_retry_timeout_flag && !resp_rcvd_q) begin
`ifdef LINKINIT_RETRY_LIMIT_EN
            if (retry_cnt_q == RETRY_CNT_W'(MAX_RETRY)) begin
              state_d = ST_ERROR;
            end else begin
              state_d     = ST_TX_REQ;
              tx_load     = 1'b1;
              tx_load_msg = SB_LINKINIT_DONE_REQ;
              retry_cnt_d = retry_cnt_q + 1'b1;
            end
`else
            state_d     = ST_TX_REQ;
            tx_load     = 1'b1;
            tx_load_msg = SB_LINKINIT_DONE_REQ;
`endif
          end
        end
        ST_TX_RESP: begin
          if (tx_sent) begin
            resp_sent_d = 1'b1;
            state_d     = ST_WAIT;
          end
        end
        ST_DONE: state_d = ST_DONE;
`ifdef LINKINIT_RETRY_LIMIT_EN
        ST_ERROR: state_d = ST_ERROR;
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, exchange flags and pulse registers.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_rcvd_q    <= 1'b0;
      resp_rcvd_q   <= 1'b0;
      resp_sent_q   <= 1'b0;
      pulse_state_q <= 1'b0;
      pulse_retry_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_rcvd_q    <= req_rcvd_d;
      resp_rcvd_q   <= resp_rcvd_d;
      resp_sent_q   <= resp_sent_d;
      pulse_state_q <= pulse_state_d;
      pulse_retry_q <= pulse_retry_d;
    end
  end

`ifdef LINKINIT_RETRY_LIMIT_EN
  // REQ retry counter.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) retry_cnt_q <= '0;
    else       retry_cnt_q <= retry_cnt_d;
  end
`endif

  assign dbg_o.state     = state_q;
  assign dbg_o.req_rcvd  = req_rcvd_q;
  assign dbg_o.resp_rcvd = resp_rcvd_q;
  assign dbg_o.resp_sent = resp_sent_q;
`ifdef LINKINIT_RETRY_LIMIT_EN
  assign dbg_o.retry_cnt = DBG_CNT_W'(retry_cnt_q);
`else
  assign dbg_o.retry_cnt = '0;
`endif

endmodule

// File: tb/tb_linkinit_state.sv
// tb_linkinit_state: directed scenarios followed by randomized traffic, all
// checked every cycle against a behavioural model of the LINKINIT exchange.
module tb_linkinit_state;
  import linkinit_state_pkg::*;

  localparam int MAX_RETRY = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          enable = 1'b0;
  logic          done, error;
  SB_msg_t       tx_msg;
  logic [63:0]   tx_data;
  logic          tx_valid;
  logic          send_next = 1'b0;
  SB_msg_t       rx_msg = SB_NONE;
  logic [63:0]   rx_data = '0;
  logic          rx_req;
  logic          rx_valid = 1'b0;
  logic          timeout = 1'b0;
  logic          rst_retry, rst_state;
  linkinit_dbg_t dbg;

  linkinit_state #(.MAX_RETRY(MAX_RETRY), .RETRY_CNT_W(3)) dut (
    .clk_100MHz                    (clk),
    .reset                         (rst),
    .enable_i                      (enable),
    .LINKINIT_done_o               (done),
    .LINKINIT_error_o              (error),
    .SB_TX_msg_o                   (tx_msg),
    .SB_TX_dataBus_o               (tx_data),
    .SB_TX_msg_valid_o             (tx_valid),
    .SB_TX_msg_sendNextFlag_i      (send_next),
    .SB_RX_msg_i                   (rx_msg),
    .SB_RX_dataBus_i               (rx_data),
    .SB_RX_msg_req_o               (rx_req),
    .SB_RX_msg_valid_i             (rx_valid),
    .SBmessage_retry_timeout_flag  (timeout),
    .reset_SBmessage_retry_timeout (rst_retry),
    .reset_state_timeout_counter_o (rst_state),
    .dbg_o                         (dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_req_tx = 0, n_resp_tx = 0, n_state_pulse = 0, n_retry_pulse = 0;
  bit random_sink = 1'b0;
  int sink_delay  = 2;
  int vcnt = 0;
  bit hs_pending = 1'b0;
  SB_msg_t hs_msg = SB_NONE;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // What the block must present after each edge, derived from the exchange
  // rules: which message is on offer, whether replies are being accepted, and
  // whether the exchange is complete or has given up.
  bit      m_started = 0, m_listen = 0, m_done = 0, m_err = 0;
  bit      m_got_req = 0, m_got_resp = 0, m_sent_resp = 0;
  bit      m_p_state = 0, m_p_retry = 0;
  SB_msg_t m_tx = SB_NONE;
  int      m_retries = 0;

  task automatic model_clear();
    m_started = 0; m_listen = 0; m_done = 0; m_err = 0;
    m_got_req = 0; m_got_resp = 0; m_sent_resp = 0;
    m_p_state = 0; m_p_retry = 0; m_tx = SB_NONE; m_retries = 0;
  endtask

  task automatic model_step();
    m_p_state = 0;
    m_p_retry = 0;
    if (!enable) begin
      model_clear();
      return;
    end
    if (!m_started) begin
      m_started = 1; m_tx = SB_LINKINIT_DONE_REQ; m_p_state = 1; m_p_retry = 1;
    end else if (m_tx != SB_NONE) begin
      if (send_next) begin
        exp_q.push_back(m_tx);
        if (m_tx == SB_LINKINIT_DONE_REQ) m_p_retry = 1;
        else m_sent_resp = 1;
        m_tx = SB_NONE;
        m_listen = 1;
      end
    end else if (m_listen) begin
      if (rx_valid) begin
        if (rx_msg == SB_LINKINIT_DONE_REQ) begin
          m_got_req = 1; m_listen = 0; m_tx = SB_LINKINIT_DONE_RESP;
        end else if (rx_msg == SB_LINKINIT_DONE_RESP) begin
          m_got_resp = 1;
        end
      end else if (m_got_resp && m_sent_resp) begin
        m_listen = 0; m_done = 1;
      end else if (timeout && !m_got_resp) begin
`ifdef LINKINIT_RETRY_LIMIT_EN
        if (m_retries == MAX_RETRY) begin
          m_listen = 0; m_err = 1;
        end else
`endif
        begin
          m_retries++; m_listen = 0; m_tx = SB_LINKINIT_DONE_REQ;
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_clear();
      exp_q.delete();
    end else begin
      model_step();
    end
  end

  // ---------------- compare + TX sink (negedge) ----------------
  always @(negedge clk) begin
    if (rst) begin
      hs_pending = 1'b0;
      vcnt = 0;
      send_next = 1'b0;
    end else begin
      if (hs_pending) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_handshake: DUT sent %0h, model expected no send", hs_msg);
        end else begin
          chk("tx_handshake_msg", hs_msg, exp_q.pop_front());
        end
        hs_pending = 1'b0;
      end
      chk("tx_msg", tx_msg, m_tx);
      chk("tx_valid", tx_valid, m_tx != SB_NONE);
      chk("tx_data_zero", tx_data, 64'd0);
      chk("rx_req", rx_req, m_listen);
      chk("done", done, m_done);
      chk("error", error, m_err);
      chk("pulse_state", rst_state, m_p_state);
      chk("pulse_retry", rst_retry, m_p_retry);
      chk("dbg_req_rcvd", dbg.req_rcvd, m_got_req);
      chk("dbg_resp_rcvd", dbg.resp_rcvd, m_got_resp);
      chk("dbg_resp_sent", dbg.resp_sent, m_sent_resp);
      if (rst_state) n_state_pulse++;
      if (rst_retry) n_retry_pulse++;
      // partner side of the TX handshake
      if (tx_valid) vcnt++;
      else vcnt = 0;
      if (random_sink) send_next = ($urandom_range(0, 1) == 1);
      else send_next = (vcnt == sink_delay);
      if (tx_valid && send_next && enable) begin
        hs_pending = 1'b1;
        hs_msg = tx_msg;
        if (tx_msg == SB_LINKINIT_DONE_REQ) n_req_tx++;
        else if (tx_msg == SB_LINKINIT_DONE_RESP) n_resp_tx++;
      end
    end
  end

  // ---------------- driver tasks (inputs change 2ns after posedge) ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_listen(input string name);
    int k = 0;
    while (!rx_req && k < 60) begin tick(1); k++; end
    chk(name, rx_req, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 60) begin tick(1); k++; end
    chk(name, done, 1'b1);
  endtask

  task automatic send_rx(input SB_msg_t m);
    int k = 0;
    rx_valid = 1'b1;
    rx_msg   = m;
    rx_data  = {$urandom, $urandom};
    while (!rx_req && k < 60) begin tick(1); k++; end
    chk("rx_consumed", rx_req, 1'b1);
    tick(1);
    rx_valid = 1'b0;
    rx_msg   = SB_NONE;
  endtask

  task automatic pulse_timeout();
    timeout = 1'b1;
    tick(1);
    timeout = 1'b0;
  endtask

  task automatic leave_state();
    enable = 1'b0;
    tick(2);
    chk("off_done", done, 1'b0);
    chk("off_valid", tx_valid, 1'b0);
    chk("off_rx_req", rx_req, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  int b_req, b_resp, b_sp, b_rp;

  initial begin
    tick(3);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_tx_msg", tx_msg, SB_NONE);
    chk("rst_rx_req", rx_req, 1'b0);
    chk("rst_pulse_state", rst_state, 1'b0);
    chk("rst_pulse_retry", rst_retry, 1'b0);
    rst = 1'b0;
    tick(2);
    chk("idle_valid", tx_valid, 1'b0);

    // nominal: partner RESP then REQ
    b_req = n_req_tx; b_resp = n_resp_tx; b_sp = n_state_pulse; b_rp = n_retry_pulse;
    enable = 1'b1;
    wait_listen("nom_listen");
    send_rx(SB_LINKINIT_DONE_RESP);
    send_rx(SB_LINKINIT_DONE_REQ);
    wait_done("nom_done");
    chk("nom_req_count", n_req_tx - b_req, 1);
    chk("nom_resp_count", n_resp_tx - b_resp, 1);
    chk("nom_state_pulses", n_state_pulse - b_sp, 1);
    chk("nom_retry_pulses", n_retry_pulse - b_rp, 2);
    tick(3);
    chk("nom_done_held", done, 1'b1);
    leave_state();

    // partner REQ before RESP
    b_req = n_req_tx; b_resp = n_resp_tx;
    enable = 1'b1;
    wait_listen("rb_listen");
    send_rx(SB_LINKINIT_DONE_REQ);
    wait_listen("rb_listen2");
    tick(3);
    chk("rb_not_done_yet", done, 1'b0);
    chk("rb_resp_sent", dbg.resp_sent, 1'b1);
    send_rx(SB_LINKINIT_DONE_RESP);
    wait_done("rb_done");
    chk("rb_req_count", n_req_tx - b_req, 1);
    chk("rb_resp_count", n_resp_tx - b_resp, 1);
    leave_state();

    // three retry timeouts -> four REQs
    b_req = n_req_tx;
    enable = 1'b1;
    wait_listen("to_listen");
    for (int i = 0; i < 3; i++) begin
      pulse_timeout();
      wait_listen("to_relisten");
    end
    chk("to_req_count", n_req_tx - b_req, 4);
    chk("to_not_done", done, 1'b0);
    send_rx(SB_LINKINIT_DONE_RESP);
    send_rx(SB_LINKINIT_DONE_REQ);
    wait_done("to_done");
    leave_state();

    // RESP and timeout in the same cycle: RX wins, no retry
    b_req = n_req_tx;
    enable = 1'b1;
    wait_listen("sim_listen");
    rx_valid = 1'b1; rx_msg = SB_LINKINIT_DONE_RESP; timeout = 1'b1;
    tick(1);
    rx_valid = 1'b0; rx_msg = SB_NONE; timeout = 1'b0;
    tick(4);
    chk("sim_resp_rcvd", dbg.resp_rcvd, 1'b1);
    chk("sim_no_extra_req", n_req_tx - b_req, 1);
    chk("sim_still_wait", rx_req, 1'b1);
    send_rx(SB_LINKINIT_DONE_REQ);
    wait_done("sim_done");
    leave_state();

    // unrelated message dropped
    enable = 1'b1;
    wait_listen("drop_listen");
    send_rx(SB_ACTIVE_REQ);
    chk("drop_still_wait", rx_req, 1'b1);
    chk("drop_no_resp", dbg.resp_rcvd, 1'b0);
    chk("drop_no_tx", tx_valid, 1'b0);
    leave_state();

    // abort while REQ is held, then a fresh REQ
    sink_delay = 1000;
    enable = 1'b1;
    tick(1);
    chk("abort_valid_held", tx_valid, 1'b1);
    chk("abort_msg_req", tx_msg, SB_LINKINIT_DONE_REQ);
    tick(1);
    enable = 1'b0;
    tick(1);
    chk("abort_valid_drop", tx_valid, 1'b0);
    chk("abort_msg_none", tx_msg, SB_NONE);
    sink_delay = 2;
    b_req = n_req_tx;
    enable = 1'b1;
    wait_listen("abort_fresh_listen");
    chk("abort_fresh_req", n_req_tx - b_req, 1);
    leave_state();

`ifdef LINKINIT_RETRY_LIMIT_EN
    // retry limit: fifth timeout ends in error, async reset clears it
    b_req = n_req_tx;
    enable = 1'b1;
    wait_listen("lim_listen");
    for (int i = 0; i < MAX_RETRY; i++) begin
      pulse_timeout();
      wait_listen("lim_relisten");
    end
    pulse_timeout();
    chk("lim_error", error, 1'b1);
    chk("lim_no_valid", tx_valid, 1'b0);
    chk("lim_no_rx_req", rx_req, 1'b0);
    tick(5);
    chk("lim_req_count", n_req_tx - b_req, MAX_RETRY + 1);
    chk("lim_error_held", error, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("lim_error_async_clear", error, 1'b0);
    enable = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
`endif

    // randomized traffic
    random_sink = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (enable) enable = ($urandom_range(0, 199) != 0);
      else        enable = ($urandom_range(0, 3) == 0);
      rx_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       rx_msg = SB_LINKINIT_DONE_REQ;
        1:       rx_msg = SB_LINKINIT_DONE_RESP;
        default: rx_msg = SB_ACTIVE_REQ;
      endcase
      rx_data = {$urandom, $urandom};
      timeout = ($urandom_range(0, 11) == 0);
      tick(1);
    end
    rx_valid = 1'b0; timeout = 1'b0; enable = 1'b0;
    random_sink = 1'b0;
    tick(3);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/linkinit_state.md
Name: linkinit_state

Overview:
- LTSM LINKINIT state handler; sits directly upstream of the ACTIVE state handler.
- Performs the sideband LINKINIT done req/resp exchange with the link partner.
- Asserts LINKINIT_done_o when the exchange completes; the LTSM top uses that level to enable ACTIVE.
- Mainband is not driven by this block. The LTSM top keeps MB pins idle during LINKINIT.

Parameters:
MAX_RETRY, 4, number of req re-sends allowed before error (used only with LINKINIT_RETRY_LIMIT_EN)
RETRY_CNT_W, 3, width of retry counter; must hold MAX_RETRY

Ports:
clk_100MHz  input  1  sideband/LTSM clock; the only clock
reset  input  1  asynchronous, active-high reset
enable_i  input  1  state enable from LTSM top
LINKINIT_done_o  output  1  exchange complete; held while enable_i=1
LINKINIT_error_o  output  1  retry limit exhausted; tied 0 without macro
SB_TX_msg_o  output  SB_msg_t  message to send
SB_TX_dataBus_o  output  64  message payload; always 0
SB_TX_msg_valid_o  output  1  TX message valid
SB_TX_msg_sendNextFlag_i  input  1  TX accepted current message
SB_RX_msg_i  input  SB_msg_t  received message
SB_RX_dataBus_i  input  64  received payload; ignored
SB_RX_msg_req_o  output  1  block ready to consume an RX message
SB_RX_msg_valid_i  input  1  RX message present
SBmessage_retry_timeout_flag  input  1  shared SB retry timer expired
reset_SBmessage_retry_timeout  output  1  1-cycle pulse restarting the retry timer
reset_state_timeout_counter_o  output  1  1-cycle pulse on state entry

Behaviour:
- Reset (async): FSM=IDLE; flags req_rcvd, resp_rcvd, resp_sent=0; retry_cnt=0.
- Reset values of all outputs: 0. SB_TX_msg_o=SB_NONE.
- FSM states: IDLE, TX_REQ, WAIT, TX_RESP, DONE, ERROR.
- IDLE:
  - enable_i=1 -> TX_REQ.
  - Same edge: pulse reset_state_timeout_counter_o and reset_SBmessage_retry_timeout for one cycle.
- TX_REQ:
  - SB_TX_msg_o=SB_LINKINIT_DONE_REQ; SB_TX_msg_valid_o=1 registered, held until SB_TX_msg_sendNextFlag_i sampled 1.
  - Then -> WAIT, valid drops the next cycle, and reset_SBmessage_retry_timeout pulses.
- WAIT: SB_RX_msg_req_o=1. A message is consumed on any cycle where req and SB_RX_msg_valid_i are both 1.
  - DONE_REQ consumed: set req_rcvd -> TX_RESP. This also applies when resp_sent=1; a partner retry is answered again.
  - DONE_RESP consumed: set resp_rcvd.
  - Any other message: consumed and dropped.
  - resp_rcvd & resp_sent -> DONE, evaluated on registered flags the cycle after the last flag sets.
  - Retry timeout: SBmessage_retry_timeout_flag=1 & !resp_rcvd -> TX_REQ, retry_cnt+1 (saturating).
  - RX message and timeout in the same cycle: RX wins. If that RX was DONE_RESP, no retry.
- TX_RESP:
  - SB_TX_msg_o=SB_LINKINIT_DONE_RESP, valid until sendNext.
  - Then set resp_sent -> WAIT.
  - SB_RX_msg_req_o=0 in this state.
- DONE: LINKINIT_done_o=1 (registered); no TX or RX activity.
- enable_i=0 in any state:
  - Next cycle -> IDLE; all flags and retry_cnt cleared; done, valid and req deassert.
  - An in-flight TX is abandoned.
- reset mid-exchange: immediate return to reset values, no partial message retained.
- SB_TX_dataBus_o is constant 0. SB_RX_dataBus_i is not inspected.

Optional Feature:
- LINKINIT_RETRY_LIMIT_EN defined:
  - A retry timeout with retry_cnt==MAX_RETRY -> ERROR instead of TX_REQ.
  - In ERROR, LINKINIT_error_o=1 and all SB outputs are 0 until enable_i=0 or reset.
  - The LTSM top routes the error to TRAINERROR.
- Not defined: retries are unbounded, the ERROR state and retry_cnt are absent, and LINKINIT_error_o is tied 0.

Decomposition:
- SB_codex_pkg (SB_codex_pkg.vh) gets new SB_msg_t enum members SB_LINKINIT_DONE_REQ and SB_LINKINIT_DONE_RESP, with encodings per the UCIe sideband codex. SB_NONE is the existing idle value.
- The FSM state enum is local to the module.
- One small sub-module is natural: sb_tx_msg_holder. It registers msg/valid and holds them until sendNextFlag.
- linkinit_state instantiates sb_tx_msg_holder for TX_REQ and TX_RESP. ACTIVE and other states can reuse it.

Test Plan:
- Nominal exchange:
  - Stimulus: enable_i=1; sendNext 2 cycles after valid; partner sends RESP, then REQ.
  - Response: REQ sent once, RESP sent once; LINKINIT_done_o=1 the cycle after resp_sent & resp_rcvd; both reset pulses exactly 1 cycle at entry.
- REQ before RESP:
  - Stimulus: partner REQ arrives while in WAIT, before RESP.
  - Response: TX_RESP happens immediately; done only after the later RESP.
- Timeout retry:
  - Stimulus: no RESP; SBmessage_retry_timeout_flag pulses 3 times.
  - Response: 4 REQ transmissions total; done stays 0; feeding RESP afterwards completes the exchange.
- Simultaneous events:
  - Stimulus: RESP valid and timeout flag in the same cycle.
  - Response: no extra REQ; resp_rcvd=1.
- Drop and abort:
  - Stimulus: an unrelated message (e.g. SB_NONE-class or ACTIVE req) in WAIT → dropped, no state change. enable_i=0 mid-TX_REQ with valid held → next cycle valid=0, FSM IDLE. Re-enable → fresh REQ.
- With LINKINIT_RETRY_LIMIT_EN, MAX_RETRY=4:
  - Stimulus: 5th timeout.
  - Response: LINKINIT_error_o=1, no 6th REQ; reset clears it asynchronously.
